ifetch_bridge: RTL and testbench

Upstream neighbour of the fetch stage. Takes the current fetch PC, issues one AXI4-Lite-style read per instruction on the instruction bus, and selects the 32-bit instruction from the 64-bit beat. Returns `instr`, `instr_valid` and `ifetch_en` to the fetch stage. Kills in-flight fetches on `jump_en` so that stale instructions are never delivered.

---
 rtl/ifetch_bridge_pkg.sv | 16 +
 rtl/ifetch_bridge_if.sv | 25 ++
 rtl/ifetch_bridge_perf_cnt.sv | 36 +++
 rtl/ifetch_bridge.sv | 132 +++++++++++++
 tb/tb_ifetch_bridge.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_bridge_pkg.sv
// Shared types and constants for the instruction-fetch bridge.
// Holds the FSM state encoding and the bus and instruction constants.
// Has no logic, so it adds no latency and has no backpressure.
package ifetch_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } ifb_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

endpackage

// File: rtl/ifetch_bridge_if.sv
// AXI4-Lite-style read channel (AR + R) between the fetch bridge and the instruction bus.
// Has no logic and no latency; AR and R use the usual valid/ready handshake.
// The master may not retract arvalid before arready.
interface ifetch_bridge_if #(
    parameter int BUS_AW = 32,
    parameter int BUS_DW = 64
);
    logic              arvalid;
    logic              arready;
    logic [BUS_AW-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [BUS_DW-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/ifetch_bridge_perf_cnt.sv
// Two 64-bit saturating event counters: delivered fetches and bus wait cycles.
// Each count updates one cycle after its increment strobe.
// No backpressure; the counters stick at all-ones.
module ifb_perf_cnt (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_inc,
    input  logic        wait_inc,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_wait_cnt
);

    logic [63:0] fetch_cnt_q, fetch_cnt_d;
    logic [63:0] wait_cnt_q,  wait_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (fetch_inc && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 64'd1;
        if (wait_inc  && (wait_cnt_q  != '1)) wait_cnt_d  = wait_cnt_q  + 64'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_wait_cnt  = wait_cnt_q;

endmodule

// File: rtl/ifetch_bridge.sv
// Issues one bus read per fetch PC and returns the selected 32-bit instruction; kills in-flight reads on jump_en.
// Latency: at least 4 cycles per instruction (IDLE, ADDR, DATA, RESP); bus wait states extend ADDR and DATA.
// Backpressure: one outstanding read; hazard_stop only drops ifetch_en. IFB_PERF_EN adds the perf counters.
module ifetch_bridge
    import ifetch_bridge_pkg::*;
#(
    parameter int BUS_AW = 32,
    parameter int BUS_DW = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] pc,
    input  logic        jump_en,
    input  logic        hazard_stop,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        ifetch_en,
    output logic        fetch_err,
`ifdef IFB_PERF_EN
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_wait_cnt,
`endif
    ifetch_bridge_if.master bus
);

    ifb_state_e        state_q, state_d;
    logic [BUS_AW-1:0] addr_q,  addr_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_q,   err_d;
    logic              kill_q,  kill_d;

    logic              arvalid_c;
    logic              rready_c;
    logic              valid_c;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        err_d       = err_q;
        kill_d      = kill_q;
        arvalid_c   = 1'b0;
        rready_c    = 1'b0;
        valid_c     = 1'b0;
        ifetch_en   = 1'b0;
        fetch_err   = 1'b0;
        instr       = NOP_INSTR;

        unique case (state_q)
            ST_IDLE: begin
                // pc is stale while a redirect is being applied.
                if (!jump_en) begin
                    addr_d = pc[BUS_AW-1:0];
                    if (pc[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        instr_d = NOP_INSTR;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                arvalid_c = 1'b1;
                if (jump_en) kill_d = 1'b1;
                if (bus.arready) state_d = ST_DATA;
            end
            ST_DATA: begin
                rready_c = 1'b1;
                if (bus.rvalid) begin
                    if (kill_q || jump_en) begin
                        kill_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        instr_d = addr_q[2] ? bus.rdata[BUS_DW-1:BUS_DW/2]
                                            : bus.rdata[BUS_DW/2-1:0];
                        err_d   = (bus.rresp != RESP_OKAY);
                        state_d = ST_RESP;
                    end
                end else if (jump_en) begin
                    // Remember a redirect seen while the beat is still pending.
                    kill_d = 1'b1;
                end
            end
            ST_RESP: begin
                valid_c   = !jump_en;
                ifetch_en = !jump_en && !hazard_stop;
                fetch_err = err_q && !jump_en;
                instr     = err_q ? NOP_INSTR : instr_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            instr_q <= NOP_INSTR;
            err_q   <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            kill_q  <= kill_d;
        end
    end

    assign instr_valid = valid_c;
    assign bus.arvalid = arvalid_c;
    assign bus.rready  = rready_c;
    assign bus.araddr  = {addr_q[BUS_AW-1:3], 3'b000};

    logic unused_bits;
    assign unused_bits = ^{pc[63:BUS_AW], addr_q[1:0]};

`ifdef IFB_PERF_EN
    ifb_perf_cnt u_perf (
        .clk            (clk),
        .rstn           (rstn),
        .fetch_inc      (valid_c),
        .wait_inc       (((state_q == ST_ADDR) && !bus.arready) ||
                         ((state_q == ST_DATA) && !bus.rvalid)),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
    );
`endif

endmodule

// File: tb/tb_ifetch_bridge.sv
// Directed bench for ifetch_bridge: cycle-by-cycle stimulus with hand-computed expectations.
module tb_ifetch_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] pc;
    logic        jump_en;
    logic        hazard_stop;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ifetch_en;
    logic        fetch_err;
`ifdef IFB_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_wait_cnt;
    logic [63:0] fetch_base;
    logic [63:0] wait_base;
`endif

    int checks = 0;
    int errors = 0;

    ifetch_bridge_if #(.BUS_AW(32), .BUS_DW(64)) bus ();

    ifetch_bridge #(.BUS_AW(32), .BUS_DW(64)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .pc             (pc),
        .jump_en        (jump_en),
        .hazard_stop    (hazard_stop),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .ifetch_en      (ifetch_en),
        .fetch_err      (fetch_err),
`ifdef IFB_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_wait_cnt  (perf_wait_cnt),
`endif
        .bus            (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rstn        = 1'b0;
        pc          = 64'h8000_0000;
        jump_en     = 1'b0;
        hazard_stop = 1'b0;
        bus.arready = 1'b1;
        bus.rvalid  = 1'b1;
        bus.rdata   = 64'h0000_0013_0010_0093;
        bus.rresp   = 2'b00;
        #3;
        chk("rst_arvalid", {63'd0, bus.arvalid}, 64'd0);
        chk("rst_rready",  {63'd0, bus.rready},  64'd0);
        chk("rst_valid",   {63'd0, instr_valid}, 64'd0);
        chk("rst_ifen",    {63'd0, ifetch_en},   64'd0);
        chk("rst_err",     {63'd0, fetch_err},   64'd0);
        chk("rst_instr",   {32'd0, instr},       64'h13);
`ifdef IFB_PERF_EN
        chk("rst_pfetch", perf_fetch_cnt, 64'd0);
        chk("rst_pwait",  perf_wait_cnt,  64'd0);
`endif
        tick();
        tick();
        rstn = 1'b1;                      // cycle 1: IDLE

        // 1: zero-wait fetch, low half
        tick(); settle();                 // cycle 2: ADDR
        chk("t1_arvalid", {63'd0, bus.arvalid}, 64'd1);
        chk("t1_araddr",  {32'd0, bus.araddr},  64'h8000_0000);
        tick(); settle();                 // cycle 3: DATA
        chk("t1_rready",  {63'd0, bus.rready},  64'd1);
        chk("t1_dvalid",  {63'd0, instr_valid}, 64'd0);
        tick(); settle();                 // cycle 4: RESP
        chk("t1_instr",   {32'd0, instr},       64'h0010_0093);
        chk("t1_valid",   {63'd0, instr_valid}, 64'd1);
        chk("t1_ifen",    {63'd0, ifetch_en},   64'd1);
        chk("t1_err",     {63'd0, fetch_err},   64'd0);
        tick();                           // IDLE
        pc = 64'h8000_0004; bus.arready = 1'b0;
        settle();
        chk("t1_idle_valid", {63'd0, instr_valid}, 64'd0);

        // 2: high half, arready low for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk("t2_arvalid_hold", {63'd0, bus.arvalid}, 64'd1);
            chk("t2_araddr_hold",  {32'd0, bus.araddr},  64'h8000_0000);
        end
        tick(); bus.arready = 1'b1; settle();
        chk("t2_arvalid_hs", {63'd0, bus.arvalid}, 64'd1);
        tick(); settle();                 // DATA
        chk("t2_dvalid", {63'd0, instr_valid}, 64'd0);
        tick(); settle();                 // RESP
        chk("t2_instr", {32'd0, instr},       64'h13);
        chk("t2_valid", {63'd0, instr_valid}, 64'd1);

        // 3: jump in DATA, rvalid late by two cycles
        tick();                           // IDLE
        pc = 64'h8000_0008; bus.rvalid = 1'b0;
        tick(); settle();                 // ADDR
        chk("t3_araddr", {32'd0, bus.araddr}, 64'h8000_0008);
        tick(); jump_en = 1'b1; settle(); // DATA, redirect
        chk("t3_rready", {63'd0, bus.rready}, 64'd1);
        tick(); jump_en = 1'b0; pc = 64'h8000_0100;
        tick(); bus.rvalid = 1'b1; bus.rdata = 64'h0020_0113_0030_0193; settle();
        chk("t3_drop_valid", {63'd0, instr_valid}, 64'd0);
        chk("t3_drop_rready", {63'd0, bus.rready}, 64'd1);
        tick(); bus.rvalid = 1'b0; settle(); // IDLE
        chk("t3_idle_valid",   {63'd0, instr_valid}, 64'd0);
        chk("t3_idle_arvalid", {63'd0, bus.arvalid}, 64'd0);
        tick(); settle();                 // ADDR to jump target
        chk("t3_target", {32'd0, bus.araddr}, 64'h8000_0100);
        tick(); bus.rvalid = 1'b1;        // DATA
        tick(); settle();                 // RESP
        chk("t3_instr", {32'd0, instr},       64'h0030_0193);
        chk("t3_valid", {63'd0, instr_valid}, 64'd1);

        // 4: jump in ADDR coincident with arready
        tick();                           // IDLE
        pc = 64'h8000_0204; bus.arready = 1'b0; bus.rvalid = 1'b0;
        tick(); jump_en = 1'b1; bus.arready = 1'b1; // ADDR
        tick(); jump_en = 1'b0; pc = 64'h8000_0300; bus.rvalid = 1'b1; settle(); // DATA
        chk("t4_rready", {63'd0, bus.rready},  64'd1);
        chk("t4_dvalid", {63'd0, instr_valid}, 64'd0);
        tick(); settle();                 // IDLE
        chk("t4_idle_valid",   {63'd0, instr_valid}, 64'd0);
        chk("t4_idle_arvalid", {63'd0, bus.arvalid}, 64'd0);
        tick(); settle();                 // ADDR
        chk("t4_target", {32'd0, bus.araddr}, 64'h8000_0300);
        tick();                           // DATA
        tick(); settle();                 // RESP
        chk("t4_instr", {32'd0, instr},       64'h0030_0193);
        chk("t4_valid", {63'd0, instr_valid}, 64'd1);

        // 5: bus error, then misaligned pc
        tick();                           // IDLE
        pc = 64'h8000_0000; bus.rresp = 2'b10;
        tick();                           // ADDR
        tick();                           // DATA
        tick(); settle();                 // RESP
        chk("t5_err",   {63'd0, fetch_err},   64'd1);
        chk("t5_valid", {63'd0, instr_valid}, 64'd1);
        chk("t5_instr", {32'd0, instr},       64'h13);
        tick();                           // IDLE
        bus.rresp = 2'b00; pc = 64'h8000_0002; settle();
        chk("t5_mis_idle_arvalid", {63'd0, bus.arvalid}, 64'd0);
        tick(); settle();                 // RESP straight from IDLE
        chk("t5_mis_arvalid", {63'd0, bus.arvalid}, 64'd0);
        chk("t5_mis_err",     {63'd0, fetch_err},   64'd1);
        chk("t5_mis_valid",   {63'd0, instr_valid}, 64'd1);
        chk("t5_mis_instr",   {32'd0, instr},       64'h13);

        // 6: hazard_stop in RESP, wait-cycle accounting, reset in DATA
        tick();                           // IDLE
        pc = 64'h8000_0000; bus.arready = 1'b0; bus.rvalid = 1'b0;
        bus.rdata = 64'h0000_0013_0010_0093;
`ifdef IFB_PERF_EN
        fetch_base = perf_fetch_cnt;
        wait_base  = perf_wait_cnt;
`endif
        tick();                           // ADDR wait 1
        tick();                           // ADDR wait 2
        tick(); bus.arready = 1'b1;       // ADDR handshake
        tick();                           // DATA wait 3
        tick(); bus.rvalid = 1'b1;        // DATA beat
        tick(); hazard_stop = 1'b1; settle(); // RESP
        chk("t6_valid", {63'd0, instr_valid}, 64'd1);
        chk("t6_ifen",  {63'd0, ifetch_en},   64'd0);
        chk("t6_instr", {32'd0, instr},       64'h0010_0093);
        tick(); hazard_stop = 1'b0; bus.rvalid = 1'b0; settle(); // IDLE
`ifdef IFB_PERF_EN
        chk("t6_pfetch", perf_fetch_cnt - fetch_base, 64'd1);
        chk("t6_pwait",  perf_wait_cnt  - wait_base,  64'd3);
`endif
        tick();                           // ADDR
        tick(); settle();                 // DATA, beat pending
        chk("t6_pre_rready", {63'd0, bus.rready}, 64'd1);
        rstn = 1'b0; settle();
        chk("t6_rst_arvalid", {63'd0, bus.arvalid}, 64'd0);
        chk("t6_rst_rready",  {63'd0, bus.rready},  64'd0);
        chk("t6_rst_valid",   {63'd0, instr_valid}, 64'd0);
        chk("t6_rst_instr",   {32'd0, instr},       64'h13);
`ifdef IFB_PERF_EN
        chk("t6_rst_pwait", perf_wait_cnt, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
